// File: rtl/mm_stage.sv
// Memory-access pipeline stage: one data-bus transaction per load/store, byte-lane
// steering, sign/zero extension, LWL/LWR merging and a registered write-back request.
// Optional: define MM_UNALIGNED_EXC_EN to trap misaligned HALF/WORD accesses
// (adds addr_exc / addr_exc_store outputs).
module mm_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [1:0]  mem_access_type,
  input  logic [2:0]  mem_access_size,
  input  logic        mem_signed,
  input  logic [31:0] mem_access_addr,
  input  logic [31:0] val_input,
  input  logic [4:0]  reg_addr_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
`ifdef MM_UNALIGNED_EXC_EN
  output logic        addr_exc,
  output logic        addr_exc_store,
`endif
  output logic        bus_err
);

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  localparam logic [1:0] AccR2R = 2'd0;
  localparam logic [1:0] AccM2R = 2'd1;
  localparam logic [1:0] AccR2M = 2'd2;

  localparam logic [2:0] SzByte  = 3'd0;
  localparam logic [2:0] SzHalf  = 3'd1;
  localparam logic [2:0] SzWord  = 3'd2;
  localparam logic [2:0] SzLeft  = 3'd3;
  localparam logic [2:0] SzRight = 3'd4;

  // Counter value on the last permitted no-ack BUS cycle.
  localparam logic [31:0] TimeoutLast = (TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 1;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        flushed_q, flushed_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;
  logic        take_op;

  // Operation latched on entry to BUS
  logic        ld_store_q, ld_signed_q;
  logic [2:0]  ld_size_q;
  logic [1:0]  ld_off_q;
  logic [31:0] ld_rt_q;
  logic [4:0]  ld_reg_q;

  logic        is_mem, misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data, m_shift;
  logic [1:0]  off;
  logic        exc_d, exc_store_d;

  assign off    = mem_access_addr[1:0];
  assign is_mem = in_valid && !flush &&
                  (mem_access_type == AccM2R || mem_access_type == AccR2M);

`ifdef MM_UNALIGNED_EXC_EN
  assign misaligned = (mem_access_size == SzHalf && off[0]) ||
                      (mem_access_size == SzWord && off != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Store lane steering from the live execute outputs
  always_comb begin
    st_be   = 4'b1111;
    st_data = val_input;
    case (mem_access_size)
      SzByte:  begin st_be = 4'b0001 << off;               st_data = {4{val_input[7:0]}}; end
      SzHalf:  begin st_be = 4'b0011 << {off[1], 1'b0};    st_data = {2{val_input[15:0]}}; end
      SzLeft:  begin st_be = 4'b1111 >> (2'd3 - off);
                     st_data = val_input >> (5'd24 - {off, 3'b000}); end
      SzRight: begin st_be = 4'b1111 << off;               st_data = val_input << {off, 3'b000}; end
      default: ;
    endcase
  end

  // Load data extraction and LWL/LWR merge from the latched op
  always_comb begin
    m_shift = bus_rdata >> {ld_off_q, 3'b000};
    ld_data = bus_rdata;
    case (ld_size_q)
      SzByte: ld_data = {{24{ld_signed_q & m_shift[7]}}, m_shift[7:0]};
      SzHalf: ld_data = {{16{ld_signed_q & m_shift[15]}}, m_shift[15:0]};
      SzLeft: begin
        case (ld_off_q)
          2'd0:    ld_data = {bus_rdata[7:0],  ld_rt_q[23:0]};
          2'd1:    ld_data = {bus_rdata[15:0], ld_rt_q[15:0]};
          2'd2:    ld_data = {bus_rdata[23:0], ld_rt_q[7:0]};
          default: ld_data = bus_rdata;
        endcase
      end
      SzRight: begin
        case (ld_off_q)
          2'd0:    ld_data = bus_rdata;
          2'd1:    ld_data = {ld_rt_q[31:24], bus_rdata[31:8]};
          2'd2:    ld_data = {ld_rt_q[31:16], bus_rdata[31:16]};
          default: ld_data = {ld_rt_q[31:8],  bus_rdata[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  // FSM next state, bus request, write-back and stall
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flushed_d   = flushed_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    exc_d       = 1'b0;
    exc_store_d = 1'b0;
    take_op     = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush && mem_access_type == AccR2R) begin
          wb_en_d   = (reg_addr_in != 5'd0);
          wb_addr_d = reg_addr_in;
          wb_data_d = val_input;
        end else if (is_mem && misaligned) begin
          exc_d       = 1'b1;
          exc_store_d = (mem_access_type == AccR2M);
        end else if (is_mem) begin
          stall     = 1'b1;
          take_op   = 1'b1;
          state_d   = StBus;
          cnt_d     = 32'd0;
          flushed_d = 1'b0;
          req_d     = 1'b1;
          we_d      = (mem_access_type == AccR2M);
          addr_d    = {mem_access_addr[31:2], 2'b00};
          be_d      = (mem_access_type == AccR2M) ? st_be : 4'b1111;
          wdata_d   = (mem_access_type == AccR2M) ? st_data : 32'd0;
        end
      end
      StBus: begin
        flushed_d = flushed_q | flush;
        if (bus_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!ld_store_q && !flushed_q && !flush) begin
            wb_en_d   = (ld_reg_q != 5'd0);
            wb_addr_d = ld_reg_q;
            wb_data_d = ld_data;
          end
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TimeoutLast) begin
          state_d = StIdle;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset is synchronous, active-high on rst_n
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 32'd0;
      flushed_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 32'd0;
      err_q       <= 1'b0;
      ld_store_q  <= 1'b0;
      ld_signed_q <= 1'b0;
      ld_size_q   <= 3'd0;
      ld_off_q    <= 2'd0;
      ld_rt_q     <= 32'd0;
      ld_reg_q    <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
      if (take_op) begin
        ld_store_q  <= (mem_access_type == AccR2M);
        ld_signed_q <= mem_signed;
        ld_size_q   <= mem_access_size;
        ld_off_q    <= off;
        ld_rt_q     <= val_input;
        ld_reg_q    <= reg_addr_in;
      end
    end
  end

`ifdef MM_UNALIGNED_EXC_EN
  logic exc_q, exc_store_q;

  // Misalignment exception pulse
  always_ff @(posedge clk) begin
    if (rst_n) begin
      exc_q       <= 1'b0;
      exc_store_q <= 1'b0;
    end else begin
      exc_q       <= exc_d;
      exc_store_q <= exc_store_d;
    end
  end

  assign addr_exc       = exc_q;
  assign addr_exc_store = exc_store_q;
`else
  logic unused_exc;
  assign unused_exc = exc_d ^ exc_store_d;
`endif

  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_byte_en = be_q;
  assign bus_wdata   = wdata_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_mm_stage.sv
// Directed bench for mm_stage (TIMEOUT_CYCLES = 4); write-backs checked against a scoreboard.
module tb_mm_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, mem_signed, bus_ack;
  logic [1:0]  mem_access_type;
  logic [2:0]  mem_access_size;
  logic [31:0] mem_access_addr, val_input, bus_rdata;
  logic [4:0]  reg_addr_in;
  logic        bus_req, bus_we, stall, wb_en, bus_err;
  logic [31:0] bus_addr, bus_wdata, wb_data;
  logic [3:0]  bus_byte_en;
  logic [4:0]  wb_addr;
`ifdef MM_UNALIGNED_EXC_EN
  logic        addr_exc, addr_exc_store;
`endif

  int passed = 0;
  int total  = 0;
  logic [36:0] sb[$];  // {reg, data}

  mm_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .mem_access_type(mem_access_type), .mem_access_size(mem_access_size),
    .mem_signed(mem_signed), .mem_access_addr(mem_access_addr), .val_input(val_input),
    .reg_addr_in(reg_addr_in), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byte_en(bus_byte_en), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef MM_UNALIGNED_EXC_EN
    .addr_exc(addr_exc), .addr_exc_store(addr_exc_store),
`endif
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write-back pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b0 && wb_en === 1'b1) begin
      total++;
      assert (sb.size() != 0) passed++;
      else $error("FAIL wb_unexpected observed=%h/%h expected=none", wb_addr, wb_data);
      if (sb.size() != 0) begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, e[36:32]});
        chk("wb_data", wb_data, e[31:0]);
      end
    end
  end

  task automatic drive(input logic [1:0] t, input logic [2:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] v, input logic [4:0] r);
    in_valid = 1'b1; mem_access_type = t; mem_access_size = sz; mem_signed = sg;
    mem_access_addr = a; val_input = v; reg_addr_in = r;
  endtask

  // One-wait-cycle load; pushes the expected write-back when reg != 0
  task automatic do_load(input string tag, input logic [2:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] rt, input logic [31:0] m,
                         input logic [4:0] r, input logic [31:0] exp);
    drive(2'd1, sz, sg, a, rt, r);
    if (r != 5'd0) sb.push_back({r, exp});
    #1 chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
    step();
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd1);
    chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, {28'd0, bus_byte_en}, 32'hF);
    bus_ack = 1'b1; bus_rdata = m; in_valid = 1'b0;
    step();
    bus_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] rt, input logic [3:0] en, input logic [31:0] wd);
    drive(2'd2, sz, 1'b0, a, rt, 5'd12);
    step();
    chk({tag, "_we"}, {31'd0, bus_we}, 32'd1);
    chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, {28'd0, bus_byte_en}, {28'd0, en});
    chk({tag, "_wdata"}, bus_wdata, wd);
    bus_ack = 1'b1; in_valid = 1'b0;
    step();
    bus_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    int stall_cnt;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_access_type = 2'd0;
    mem_access_size = 3'd0; mem_signed = 1'b0; mem_access_addr = 32'd0;
    val_input = 32'd0; reg_addr_in = 5'd0; bus_rdata = 32'd0; bus_ack = 1'b0;
    step(); step();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_be", {28'd0, bus_byte_en}, 32'd0);
    rst_n = 1'b0;
    step();

    // R2R write-back
    drive(2'd0, 3'd2, 1'b0, 32'd0, 32'h1234_5678, 5'd5);
    sb.push_back({5'd5, 32'h1234_5678});
    #1 chk("r2r_stall", {31'd0, stall}, 32'd0);
    step();
    chk("r2r_no_req", {31'd0, bus_req}, 32'd0);
    in_valid = 1'b0;
    step();
    chk("r2r_pulse", {31'd0, wb_en}, 32'd0);
    // R2R to r0: no write-back
    drive(2'd0, 3'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0);
    step();
    in_valid = 1'b0;
    chk("r2r_r0", {31'd0, wb_en}, 32'd0);

    // LB signed, three no-ack BUS cycles then ack
    drive(2'd1, 3'd0, 1'b1, 32'h0000_1003, 32'd0, 5'd3);
    sb.push_back({5'd3, 32'hFFFF_FF80});
    stall_cnt = 0;
    #1 if (stall === 1'b1) stall_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (stall === 1'b1) stall_cnt++;
    end
    chk("lb_addr", bus_addr, 32'h0000_1000);
    chk("lb_be", {28'd0, bus_byte_en}, 32'hF);
    chk("lb_we", {31'd0, bus_we}, 32'd0);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h80FF_0000; in_valid = 1'b0;
    #1 chk("lb_stall_ack", {31'd0, stall}, 32'd0);
    chk("lb_stall_cycles", stall_cnt, 32'd4);
    step();
    bus_ack = 1'b0;
    chk("lb_req_drop", {31'd0, bus_req}, 32'd0);
    chk("lb_no_err", {31'd0, bus_err}, 32'd0);

    // Store lane steering
    do_store("swr", 3'd4, 32'h0000_2001, 32'hAABB_CCDD, 4'b1110, 32'hBBCC_DD00);
    do_store("sb",  3'd0, 32'h0000_3002, 32'h0000_00A5, 4'b0100, 32'hA5A5_A5A5);
    do_store("swl", 3'd3, 32'h0000_3001, 32'hAABB_CCDD, 4'b0011, 32'h0000_AABB);
    do_store("sh",  3'd1, 32'h0000_3002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
    do_store("sw",  3'd2, 32'h0000_3004, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    // Load extraction and merging
    do_load("lwl", 3'd3, 1'b0, 32'h0000_5001, 32'hAABB_CCDD, 32'h1122_3344, 5'd4, 32'h3344_CCDD);
    do_load("lwr", 3'd4, 1'b0, 32'h0000_5002, 32'hAABB_CCDD, 32'h1122_3344, 5'd6, 32'hAABB_1122);
    do_load("lhu", 3'd1, 1'b0, 32'h0000_5002, 32'd0, 32'h8001_7FFF, 5'd11, 32'h0000_8001);
    do_load("lh",  3'd1, 1'b1, 32'h0000_5000, 32'd0, 32'h1234_8765, 5'd13, 32'hFFFF_8765);
    do_load("lw",  3'd2, 1'b0, 32'h0000_5008, 32'd0, 32'hDEAD_BEEF, 5'd9, 32'hDEAD_BEEF);
    do_load("lbu", 3'd0, 1'b0, 32'h0000_5001, 32'd0, 32'h0000_9A00, 5'd14, 32'h0000_009A);
    do_load("lr0", 3'd2, 1'b0, 32'h0000_5000, 32'd0, 32'h5555_5555, 5'd0, 32'd0);

    // Timeout: no ack for 4 BUS cycles
    drive(2'd1, 3'd2, 1'b0, 32'h0000_4000, 32'd0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_stall_wait", {31'd0, stall}, 32'd1);
    end
    step();
    chk("to_stall_last", {31'd0, stall}, 32'd0);
    chk("to_req_last", {31'd0, bus_req}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("to_req_drop", {31'd0, bus_req}, 32'd0);
    chk("to_err", {31'd0, bus_err}, 32'd1);
    step();
    chk("to_err_pulse", {31'd0, bus_err}, 32'd0);

    // Flush during BUS: ack accepted, no write-back
    drive(2'd1, 3'd2, 1'b0, 32'h0000_6000, 32'd0, 5'd7);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_req_held", {31'd0, bus_req}, 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777; in_valid = 1'b0;
    step();
    bus_ack = 1'b0;
    chk("fl_req_drop", {31'd0, bus_req}, 32'd0);
    step();

    // Flush in IDLE beats in_valid
    drive(2'd1, 3'd2, 1'b0, 32'h0000_6000, 32'd0, 5'd7);
    flush = 1'b1;
    #1 chk("fli_stall", {31'd0, stall}, 32'd0);
    step();
    chk("fli_no_req", {31'd0, bus_req}, 32'd0);
    drive(2'd0, 3'd2, 1'b0, 32'd0, 32'h1111_1111, 5'd7);
    step();
    chk("fli_r2r", {31'd0, wb_en}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;

    // Reset mid-transaction; later ack ignored
    drive(2'd1, 3'd2, 1'b0, 32'h0000_7000, 32'd0, 5'd10);
    step();
    chk("rm_req", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("rm_req_drop", {31'd0, bus_req}, 32'd0);
    rst_n = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_CAFE;
    step();
    bus_ack = 1'b0;
    chk("rm_no_wb", {31'd0, wb_en}, 32'd0);
    chk("rm_no_req", {31'd0, bus_req}, 32'd0);
    step(); step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
